// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the capture-buffer read engine: default geometry
// matching the capture RAM and the controller state encoding.
package ram_stream_reader_pkg;

  localparam int ASIZE_DEF = 13;
  localparam int DSIZE_DEF = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

endpackage

// File: rtl/ram_stream_reader_if.sv
// RAM read port plus outgoing valid/ready word stream of the read engine.
// The master side is the reader; the slave side is the RAM and the consumer.
interface ram_stream_reader_if
  import ram_stream_reader_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF,
  parameter int DSIZE = DSIZE_DEF
) ();

  logic [ASIZE-1:0] o_rd_addr;
  logic [DSIZE-1:0] i_rd_data;
  logic [DSIZE-1:0] o_data;
  logic             o_valid;
  logic             o_last;
  logic             i_ready;

  modport master (
    output o_rd_addr,
    input  i_rd_data,
    output o_data,
    output o_valid,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_rd_addr,
    output i_rd_data,
    input  o_data,
    input  o_valid,
    input  o_last,
    output i_ready
  );

endinterface

// File: rtl/ram_stream_reader.sv
// Walks the capture RAM's asynchronous read port from a start address for a
// word count and streams the words out on valid/ready with wrap and abort.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF,
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [ASIZE-1:0] i_start_addr,
  input  logic [ASIZE:0]   i_length,
  input  logic             i_abort,
  ram_stream_reader_if.master bus,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [ASIZE:0]   LEN_MAX  = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0]   LEN_ZERO = '0;
  localparam logic [ASIZE:0]   LEN_ONE  = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE-1:0] ADDR_ONE = {{(ASIZE-1){1'b0}}, 1'b1};

  // Requests longer than the buffer read every word exactly once.
  function automatic logic [ASIZE:0] clamp_len(input logic [ASIZE:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  state_t           state;
  logic [ASIZE:0]   remaining;
  logic [ASIZE-1:0] rd_addr;
  logic [DSIZE-1:0] data_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;

  logic [ASIZE:0]   len_clamped;
  logic             take_start;
  logic             beat_slot;
  logic             do_abort;
  logic             do_load;
  logic             do_finish;

  always_comb begin
    len_clamped = clamp_len(i_length);
    take_start  = (state == ST_IDLE) && i_start && !i_abort;
    do_abort    = (state != ST_IDLE) && i_abort;
    // LOAD always fills the output slot; STREAM refills it only when the held word leaves.
    beat_slot   = (state == ST_LOAD) ||
                  ((state == ST_STREAM) && valid_q && bus.i_ready);
    do_load     = !do_abort && beat_slot && (remaining != LEN_ZERO);
    do_finish   = !do_abort && beat_slot && (remaining == LEN_ZERO);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      rd_addr   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (take_start) begin
        rd_addr <= i_start_addr;
        if (len_clamped == LEN_ZERO) begin
          done_q <= 1'b1;
        end else begin
          remaining <= len_clamped;
          busy_q    <= 1'b1;
          state     <= ST_LOAD;
        end
      end

      // Address increment wraps naturally at the buffer boundary.
      if (do_load) begin
        data_q    <= bus.i_rd_data;
        valid_q   <= 1'b1;
        last_q    <= (remaining == LEN_ONE);
        rd_addr   <= rd_addr + ADDR_ONE;
        remaining <= remaining - LEN_ONE;
        state     <= ST_STREAM;
      end

      if (do_finish) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        state   <= ST_IDLE;
      end

      if (do_abort) begin
        valid_q   <= 1'b0;
        last_q    <= 1'b0;
        busy_q    <= 1'b0;
        remaining <= '0;
        state     <= ST_IDLE;
      end
    end
  end

  assign bus.o_rd_addr = rd_addr;
  assign bus.o_data    = data_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_last    = last_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: an async-read RAM model preloaded with
// mem[a]=a[7:0], a beat scoreboard, a transfer table and corner sequences.
module tb_ram_stream_reader;
  import ram_stream_reader_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [12:0] addr;
    logic [13:0] len;
    int          exp_beats;
    logic [7:0]  exp_last_data;
    logic [12:0] exp_end_addr;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [12:0] i_start_addr = '0;
  logic [13:0] i_length = '0;
  logic        i_abort = 1'b0;
  logic        o_busy;
  logic        o_done;

  logic [7:0]  mem [0:8191];

  int n_checks = 0;
  int n_fail   = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  logic [7:0] last_data = '0;
  exp_t exp_q[$];

  ram_stream_reader_if #(.ASIZE(13), .DSIZE(8)) bus ();

  ram_stream_reader #(.ASIZE(13), .DSIZE(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_start_addr (i_start_addr),
    .i_length     (i_length),
    .i_abort      (i_abort),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  assign bus.i_rd_data = mem[bus.o_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a beat is taken at the next rising edge when valid & ready here.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_done) done_cnt++;
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", bus.o_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_data", {24'd0, bus.o_data}, {24'd0, e.data});
          chk("beat_last", {31'd0, bus.o_last}, {31'd0, e.last});
          beat_cnt++;
          if (bus.o_last) last_data = bus.o_data;
        end
      end
    end
  end

  task automatic do_start(input logic [12:0] a, input logic [13:0] l);
    int n;
    n = (l > 14'd8192) ? 8192 : int'(l);
    for (int i = 0; i < n; i++) exp_q.push_back('{mem[13'(int'(a) + i)], (i == n - 1)});
    i_start_addr = a;
    i_length     = l;
    i_start      = 1'b1;
    @(posedge i_clk); #1;
    i_start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c;
    c = 0;
    while (!o_done && c < budget) begin
      @(posedge i_clk); #1;
      c++;
    end
    chk(name, {31'd0, o_done}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    beat_cnt  = 0;
    done_cnt  = 0;
    last_data = '0;
    bus.i_ready = 1'b1;
    do_start(v.addr, v.len);
    chk("start_busy",    {31'd0, o_busy}, 32'd1);
    chk("start_rd_addr", {19'd0, bus.o_rd_addr}, {19'd0, v.addr});
    chk("start_valid",   {31'd0, bus.o_valid}, 32'd0);
    @(posedge i_clk); #1;
    chk("first_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("first_data",  {24'd0, bus.o_data}, {24'd0, v.addr[7:0]});
    wait_done(v.exp_beats + 8, "done_seen");
    chk("end_busy",    {31'd0, o_busy}, 32'd0);
    chk("end_rd_addr", {19'd0, bus.o_rd_addr}, {19'd0, v.exp_end_addr});
    @(posedge i_clk); #1;
    chk("done_drop",   {31'd0, o_done}, 32'd0);
    chk("beat_count",  beat_cnt, v.exp_beats);
    chk("last_data",   {24'd0, last_data}, {24'd0, v.exp_last_data});
    chk("done_pulses", done_cnt, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;

    for (int a = 0; a < 8192; a++) mem[a] = a[7:0];

    vecs[0] = '{13'h0010, 14'd4,      4,    8'h13, 13'h0014};
    vecs[1] = '{13'h1FFE, 14'd4,      4,    8'h01, 13'h0002};
    vecs[2] = '{13'h00FF, 14'd1,      1,    8'hFF, 13'h0100};
    vecs[3] = '{13'h0500, 14'd16,     16,   8'h0F, 13'h0510};
    vecs[4] = '{13'h0000, 14'h3FFF,   8192, 8'hFF, 13'h0000};
    vecs[5] = '{13'h0010, 14'h2000,   8192, 8'h0F, 13'h0010};

    bus.i_ready = 1'b1;
    #1 i_rst = 1'b1;
    #1;
    chk("rst_rd_addr", {19'd0, bus.o_rd_addr}, 32'd0);
    chk("rst_data",    {24'd0, bus.o_data}, 32'd0);
    chk("rst_valid",   {31'd0, bus.o_valid}, 32'd0);
    chk("rst_last",    {31'd0, bus.o_last}, 32'd0);
    chk("rst_busy",    {31'd0, o_busy}, 32'd0);
    chk("rst_done",    {31'd0, o_done}, 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: ready 1,0,0,1,1 from the first valid cycle.
    beat_cnt = 0; done_cnt = 0;
    do_start(13'h0020, 14'd3);
    @(posedge i_clk); #1;
    chk("bp_first", {24'd0, bus.o_data}, 32'h20);
    @(posedge i_clk); #1;
    bus.i_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(posedge i_clk); #1;
      chk("bp_stall_data",  {24'd0, bus.o_data}, 32'h21);
      chk("bp_stall_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("bp_stall_last",  {31'd0, bus.o_last}, 32'd0);
      chk("bp_stall_addr",  {19'd0, bus.o_rd_addr}, 32'h22);
    end
    bus.i_ready = 1'b1;
    wait_done(10, "bp_done_seen");
    @(posedge i_clk); #1;
    chk("bp_beats", beat_cnt, 32'd3);
    chk("bp_done_pulses", done_cnt, 32'd1);

    // Zero length completes immediately without a beat.
    done_cnt = 0;
    do_start(13'h0050, 14'd0);
    chk("len0_done",  {31'd0, o_done}, 32'd1);
    chk("len0_busy",  {31'd0, o_busy}, 32'd0);
    chk("len0_valid", {31'd0, bus.o_valid}, 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("len0_done_drop", {31'd0, o_done}, 32'd0);
    chk("len0_valid_later", {31'd0, bus.o_valid}, 32'd0);
    chk("len0_done_pulses", done_cnt, 32'd1);

    // Start while busy is ignored.
    beat_cnt = 0; done_cnt = 0;
    do_start(13'h0100, 14'd4);
    @(posedge i_clk); #1;
    i_start_addr = 13'h0200; i_length = 14'd5; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done(20, "busy_start_done_seen");
    chk("busy_start_end_addr", {19'd0, bus.o_rd_addr}, 32'h104);
    @(posedge i_clk); #1;
    chk("busy_start_beats", beat_cnt, 32'd4);
    chk("busy_start_idle", {31'd0, o_busy}, 32'd0);

    // Abort after two accepted beats of a ten-word transfer.
    beat_cnt = 0; done_cnt = 0;
    do_start(13'h0040, 14'd10);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    exp_q.delete();
    chk("abort_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("abort_last",  {31'd0, bus.o_last}, 32'd0);
    chk("abort_busy",  {31'd0, o_busy}, 32'd0);
    chk("abort_done",  {31'd0, o_done}, 32'd0);
    chk("abort_beats", beat_cnt, 32'd2);
    repeat (3) @(posedge i_clk);
    #1;
    chk("abort_no_done", done_cnt, 32'd0);
    v = '{13'h0300, 14'd3, 3, 8'h02, 13'h0303};
    run_vec(v);

    // Asynchronous reset in the middle of a transfer.
    do_start(13'h0400, 14'd10);
    @(posedge i_clk); #1;
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    #1;
    chk("arst_valid",   {31'd0, bus.o_valid}, 32'd0);
    chk("arst_busy",    {31'd0, o_busy}, 32'd0);
    chk("arst_rd_addr", {19'd0, bus.o_rd_addr}, 32'd0);
    chk("arst_data",    {24'd0, bus.o_data}, 32'd0);
    chk("arst_last",    {31'd0, bus.o_last}, 32'd0);
    chk("arst_done",    {31'd0, o_done}, 32'd0);
    exp_q.delete();
    @(posedge i_clk); #3;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("arst_after_valid", {31'd0, bus.o_valid}, 32'd0);
    v = '{13'h0600, 14'd2, 2, 8'h01, 13'h0602};
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
